// File: rtl/psum_fuse_unit_if.sv
// Bundle of control, psum SRAM read, fused-row stream and peer-sum exchange signals for psum_fuse_unit.
interface psum_fuse_unit_if #(
    parameter int COL     = 8,
    parameter int BW_PSUM = 12,
    parameter int BW_OUT  = 16,
    parameter int ADDR_W  = 4,
    parameter int SUM_W   = 24
);
    logic                     start;
    logic [1:0]               mode;
    logic [ADDR_W-1:0]        base_addr;
    logic [ADDR_W:0]          num_rows;
    logic                     busy;
    logic                     done;
    logic                     pmem_rd;
    logic [ADDR_W-1:0]        pmem_add;
    logic [COL*BW_PSUM-1:0]   pmem_out;
    logic                     out_valid;
    logic                     out_ready;
    logic [COL*BW_OUT-1:0]    out_data;
    logic [ADDR_W-1:0]        out_add;
    logic [SUM_W-1:0]         sum_out;
    logic [SUM_W-1:0]         sum_in;
    logic                     sum_in_valid;
    logic [SUM_W-1:0]         total_sum;
    logic                     total_valid;

    modport master (
        output start, mode, base_addr, num_rows, pmem_out, out_ready, sum_in, sum_in_valid,
        input  busy, done, pmem_rd, pmem_add, out_valid, out_data, out_add, sum_out,
               total_sum, total_valid
    );

    modport slave (
        input  start, mode, base_addr, num_rows, pmem_out, out_ready, sum_in, sum_in_valid,
        output busy, done, pmem_rd, pmem_add, out_valid, out_data, out_add, sum_out,
               total_sum, total_valid
    );
endinterface

// File: rtl/psum_fuse_unit.sv
// Reads psum rows, fuses neighbour lanes per mode, streams them through a 2-entry FIFO,
// and accumulates a |x| row-sum that is combined with the peer core's sum.
module psum_fuse_unit #(
    parameter int COL     = 8,
    parameter int BW_PSUM = 12,
    parameter int BW_OUT  = 16,
    parameter int SHIFT   = 4,
    parameter int ADDR_W  = 4,
    parameter int SUM_W   = 24
) (
    input logic            clk,
    input logic            reset,
    psum_fuse_unit_if.slave bus
);
    localparam int ROW_W = BW_OUT + 2 + $clog2(COL);
    localparam int ACC_W = ((ROW_W > SUM_W) ? ROW_W : SUM_W) + 1;
    localparam logic [ADDR_W:0] ROW_ONE = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, EXCH = 2'd3} state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q;
    logic [ADDR_W-1:0]     base_q;
    logic [ADDR_W:0]       nrows_q;
    logic [ADDR_W:0]       rd_cnt_q;
    logic                  inflight_q;
    logic [ADDR_W-1:0]     inflight_addr_q;
    logic [COL*BW_OUT-1:0] fifo_data_q [2];
    logic [ADDR_W-1:0]     fifo_addr_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            cnt_q;
    logic [SUM_W-1:0]      sum_q, total_q;
    logic                  total_valid_q, done_q;

    logic                  start_acc_s, pmem_rd_s, exch_fire_s, push_s, pop_s, last_rd_s;
    logic [ADDR_W-1:0]     pmem_add_s;
    logic [2:0]            occ_s;
    logic signed [BW_OUT-1:0] s_lane [COL];
    logic [BW_OUT-1:0]     f_lane [COL];
    logic [COL*BW_OUT-1:0] fused_s;
    logic [ROW_W-1:0]      row_sum_s;

    function automatic logic [BW_OUT:0] abs_lane(input logic [BW_OUT-1:0] x);
        logic [BW_OUT:0] w;
        w = {x[BW_OUT-1], x};
        if (x[BW_OUT-1]) abs_lane = -w;
        else             abs_lane = w;
    endfunction

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [ACC_W-1:0] b);
        logic [ACC_W-1:0] s;
        s = ACC_W'(a) + b;
        if (s > ACC_W'({SUM_W{1'b1}})) sat_add = {SUM_W{1'b1}};
        else                           sat_add = s[SUM_W-1:0];
    endfunction

    // A read returning this cycle is pushed; the pop frees a slot in the same cycle.
    assign push_s     = inflight_q;
    assign pop_s      = (cnt_q != 2'd0) && bus.out_ready;
    assign occ_s      = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    assign pmem_add_s = base_q + rd_cnt_q[ADDR_W-1:0];
    assign last_rd_s  = (rd_cnt_q == (nrows_q - ROW_ONE));

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = (bus.num_rows == '0) ? EXCH : READ;
                else           state_d = IDLE;
            end
            READ: begin
                if (pmem_rd_s && last_rd_s) state_d = DRAIN;
                else                        state_d = READ;
            end
            DRAIN: begin
                if ((cnt_q == 2'd0) && !inflight_q) state_d = EXCH;
                else                                state_d = DRAIN;
            end
            EXCH: begin
                if (bus.sum_in_valid) state_d = IDLE;
                else                  state_d = EXCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: start acceptance, read issue, peer-sum capture
    always_comb begin
        start_acc_s = 1'b0;
        pmem_rd_s   = 1'b0;
        exch_fire_s = 1'b0;
        case (state_q)
            IDLE:    start_acc_s = bus.start;
            READ:    pmem_rd_s   = (occ_s < 3'd2);
            DRAIN:   pmem_rd_s   = 1'b0;
            EXCH:    exch_fire_s = bus.sum_in_valid;
            default: pmem_rd_s   = 1'b0;
        endcase
    end

    // Lane fusion of the returning row and its |x| sum
    always_comb begin
        for (int k = 0; k < COL; k++) begin
            s_lane[k] = BW_OUT'($signed(bus.pmem_out[k*BW_PSUM +: BW_PSUM]));
            f_lane[k] = '0;
        end
        case (mode_q)
            2'd1: begin
                for (int j = 0; j < COL/2; j++)
                    f_lane[j] = (s_lane[2*j+1] << SHIFT) + s_lane[2*j];
            end
            2'd2: begin
                for (int j = 0; j < COL/4; j++)
                    f_lane[j] = (s_lane[4*j+3] << (3*SHIFT)) + (s_lane[4*j+2] << (2*SHIFT))
                              + (s_lane[4*j+1] << SHIFT) + s_lane[4*j];
            end
            default: begin
                for (int k = 0; k < COL; k++) f_lane[k] = s_lane[k];
            end
        endcase
        fused_s   = '0;
        row_sum_s = '0;
        for (int k = 0; k < COL; k++) begin
            fused_s[k*BW_OUT +: BW_OUT] = f_lane[k];
            row_sum_s = row_sum_s + ROW_W'(abs_lane(f_lane[k]));
        end
    end

    // Pass parameters, read tracking, local sum and peer-sum exchange
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q          <= 2'd0;
            base_q          <= '0;
            nrows_q         <= '0;
            rd_cnt_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            sum_q           <= '0;
            total_q         <= '0;
            total_valid_q   <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            inflight_q <= pmem_rd_s;
            done_q     <= exch_fire_s;
            if (pmem_rd_s) inflight_addr_q <= pmem_add_s;
            if (start_acc_s) begin
                mode_q        <= bus.mode;
                base_q        <= bus.base_addr;
                nrows_q       <= bus.num_rows;
                rd_cnt_q      <= '0;
                sum_q         <= '0;
                total_q       <= '0;
                total_valid_q <= 1'b0;
            end else begin
                if (pmem_rd_s) rd_cnt_q <= rd_cnt_q + ROW_ONE;
                if (push_s)    sum_q    <= sat_add(sum_q, ACC_W'(row_sum_s));
                if (exch_fire_s) begin
                    total_q       <= sat_add(sum_q, ACC_W'(bus.sum_in));
                    total_valid_q <= 1'b1;
                end
            end
        end
    end

    // Two-entry output FIFO of {fused row, source address}
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < 2; e++) begin
                fifo_data_q[e] <= '0;
                fifo_addr_q[e] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_data_q[wr_ptr_q] <= fused_s;
                fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop_s) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.pmem_rd     = pmem_rd_s;
    assign bus.pmem_add    = pmem_add_s;
    assign bus.out_valid   = (cnt_q != 2'd0);
    assign bus.out_data    = fifo_data_q[rd_ptr_q];
    assign bus.out_add     = fifo_addr_q[rd_ptr_q];
    assign bus.sum_out     = sum_q;
    assign bus.total_sum   = total_q;
    assign bus.total_valid = total_valid_q;
endmodule

// File: tb/tb_psum_fuse_unit.sv
// Directed, table-driven bench for psum_fuse_unit with an SRAM model and per-cycle FIFO/issue tracking.
module tb_psum_fuse_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    psum_fuse_unit_if #(.COL(8), .BW_PSUM(12), .BW_OUT(16), .ADDR_W(4), .SUM_W(24)) bus ();
    psum_fuse_unit dut (.clk(clk), .reset(reset), .bus(bus));

    logic [95:0] mem [16];
    always @(posedge clk) if (bus.pmem_rd) bus.pmem_out <= mem[bus.pmem_add];

    typedef struct {
        logic [1:0]   mode;
        logic [95:0]  row;
        logic [127:0] exp_data;
        logic [23:0]  exp_sum;
    } vec_t;
    vec_t vecs [6];

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] got_data [$];
    logic [3:0]   got_addr [$];
    logic [3:0]   rd_addr  [$];
    int           hs_cyc   [$];
    int           rd_cyc   [$];
    int           viol, vld_err, clr_err;
    bit           timeout;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [127:0] ref_fuse(input logic [1:0] m, input logic [95:0] row);
        int g, v;
        int s [8];
        logic signed [11:0] c;
        g = (m == 2'd1) ? 2 : ((m == 2'd2) ? 4 : 1);
        for (int k = 0; k < 8; k++) begin
            c = row[k*12 +: 12];
            s[k] = c;
        end
        ref_fuse = '0;
        for (int j = 0; j < 8/g; j++) begin
            v = 0;
            for (int q = 0; q < g; q++) v += s[j*g+q] * (1 << (q*4));
            ref_fuse[j*16 +: 16] = v[15:0];
        end
    endfunction

    function automatic int ref_abs_sum(input logic [127:0] d);
        logic signed [15:0] x;
        ref_abs_sum = 0;
        for (int k = 0; k < 8; k++) begin
            x = d[k*16 +: 16];
            ref_abs_sum += (x < 0) ? -int'(x) : int'(x);
        end
    endfunction

    // Starts a pass at posedge+#1 and samples every negedge until done or budget.
    task automatic run_pass(input logic [1:0] m, input logic [3:0] base, input logic [4:0] n,
                            input int rdy_mod, input logic [23:0] peer, input bit poke);
        int occ, rdp, cyc;
        bit pop, done_seen;
        got_data.delete(); got_addr.delete(); rd_addr.delete(); hs_cyc.delete(); rd_cyc.delete();
        viol = 0; vld_err = 0; clr_err = 0; timeout = 1'b0;
        bus.start = 1'b1; bus.mode = m; bus.base_addr = base; bus.num_rows = n;
        bus.sum_in = peer; bus.sum_in_valid = 1'b0; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mode = 2'd2; bus.base_addr = 4'd9; bus.num_rows = 5'd3;
        occ = 0; rdp = 0; cyc = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 600) begin
            bus.out_ready    = (rdy_mod <= 1) ? 1'b1 : ((cyc % rdy_mod) == 0);
            bus.sum_in_valid = 1'b1;
            bus.start        = poke && (cyc == 5);
            @(negedge clk);
            if (cyc == 0 && (bus.sum_out != 24'd0 || bus.total_sum != 24'd0 || bus.total_valid)) clr_err++;
            pop = bus.out_valid && bus.out_ready;
            if (bus.out_valid !== (occ != 0)) vld_err++;
            if (bus.pmem_rd && (occ + rdp - int'(pop) >= 2)) viol++;
            if (bus.pmem_rd) begin rd_addr.push_back(bus.pmem_add); rd_cyc.push_back(cyc); end
            if (pop) begin got_data.push_back(bus.out_data); got_addr.push_back(bus.out_add); hs_cyc.push_back(cyc); end
            if (bus.done) done_seen = 1'b1;
            occ = occ + rdp - int'(pop);
            rdp = int'(bus.pmem_rd);
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0; bus.sum_in_valid = 1'b0; bus.out_ready = 1'b0;
        if (!done_seen) timeout = 1'b1;
    endtask

    // Compares every streamed row, its address and the read order against the reference model.
    task automatic check_rows(input string tag, input logic [1:0] m, input logic [3:0] base, input int n);
        int derr, aerr, rerr, s;
        logic [3:0] a;
        derr = 0; aerr = 0; rerr = 0; s = 0;
        check({tag, "_timeout"}, timeout, 1'b0);
        check({tag, "_rows"}, got_data.size(), n);
        check({tag, "_reads"}, rd_addr.size(), n);
        for (int i = 0; i < n; i++) begin
            a = base + 4'(i);
            s += ref_abs_sum(ref_fuse(m, mem[a]));
            if (i < got_data.size()) begin
                if (got_data[i] !== ref_fuse(m, mem[a])) derr++;
                if (got_addr[i] !== a) aerr++;
            end
            if (i < rd_addr.size() && rd_addr[i] !== a) rerr++;
        end
        check({tag, "_data_errs"}, derr, 0);
        check({tag, "_addr_errs"}, aerr, 0);
        check({tag, "_rdaddr_errs"}, rerr, 0);
        check({tag, "_sum_out"}, bus.sum_out, 24'(s));
        check({tag, "_valid_model_errs"}, vld_err, 0);
        check({tag, "_issue_viol"}, viol, 0);
    endtask

    initial begin
        logic [127:0] d0;
        logic [3:0]   a0;
        int           zr_bad, cyc;
        bit           seen;

        vecs[0] = '{2'd1, 96'h000_000_000_000_002_FFF_003_005, 128'h0000_0000_0000_0000_0000_0000_001F_0035, 24'd84};
        vecs[1] = '{2'd2, 96'h000_000_000_000_001_001_001_001, 128'h0000_0000_0000_0000_0000_0000_0000_1111, 24'd4369};
        vecs[2] = '{2'd0, 96'h000_000_000_000_001_FFF_800_7FF, 128'h0000_0000_0000_0000_0001_FFFF_F800_07FF, 24'd4097};
        vecs[3] = '{2'd3, 96'h123_000_000_000_000_000_000_FFE, 128'h0123_0000_0000_0000_0000_0000_0000_FFFE, 24'd293};
        vecs[4] = '{2'd2, 96'h000_000_000_FFF_7FF_7FF_7FF_7FF, 128'h0000_0000_0000_0000_0000_0000_FFFF_76EF, 24'd30448};
        vecs[5] = '{2'd1, 96'h001_001_000_000_000_000_800_800, 128'h0000_0000_0000_0000_0011_0000_0000_7800, 24'd30737};

        reset = 1'b1;
        bus.start = 1'b0; bus.mode = 2'd0; bus.base_addr = 4'd0; bus.num_rows = 5'd0;
        bus.out_ready = 1'b0; bus.sum_in = 24'd0; bus.sum_in_valid = 1'b0; bus.pmem_out = '0;
        for (int a = 0; a < 16; a++) mem[a] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_pmem_rd", bus.pmem_rd, 1'b0);
        check("rst_sum_out", bus.sum_out, 24'd0);
        check("rst_total_valid", bus.total_valid, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            mem[i] = vecs[i].row;
            run_pass(vecs[i].mode, 4'(i), 5'd1, 1, 24'(100*i + 7), 1'b0);
            d0 = (got_data.size() > 0) ? got_data[0] : 'x;
            a0 = (got_addr.size() > 0) ? got_addr[0] : 'x;
            check($sformatf("tbl%0d_timeout", i), timeout, 1'b0);
            check($sformatf("tbl%0d_rows", i), got_data.size(), 1);
            check($sformatf("tbl%0d_data", i), d0, vecs[i].exp_data);
            check($sformatf("tbl%0d_addr", i), a0, 4'(i));
            check($sformatf("tbl%0d_sum_out", i), bus.sum_out, vecs[i].exp_sum);
            check($sformatf("tbl%0d_total", i), bus.total_sum, 24'(vecs[i].exp_sum + 24'(100*i + 7)));
            check($sformatf("tbl%0d_total_valid", i), bus.total_valid, 1'b1);
            check($sformatf("tbl%0d_clear_on_start", i), clr_err, 0);
            check($sformatf("tbl%0d_valid_model", i), vld_err, 0);
        end

        for (int a = 0; a < 16; a++)
            for (int k = 0; k < 8; k++) mem[a][k*12 +: 12] = 12'(a*293 + k*611 + 5);

        // Address wrap with full-rate streaming
        run_pass(2'd0, 4'd14, 5'd4, 1, 24'd0, 1'b0);
        check_rows("wrap", 2'd0, 4'd14, 4);
        if (hs_cyc.size() == 4 && rd_cyc.size() == 4) begin
            check("wrap_rd_contig", rd_cyc[3] - rd_cyc[0], 3);
            check("wrap_out_contig", hs_cyc[3] - hs_cyc[0], 3);
            check("wrap_latency", hs_cyc[0] - rd_cyc[0], 2);
        end else begin
            check("wrap_handshake_count", hs_cyc.size(), 4);
        end

        // Backpressure: ready 1-of-3 over all 16 rows, stray start while busy
        run_pass(2'd1, 4'd3, 5'd16, 3, 24'd5, 1'b1);
        check_rows("bp", 2'd1, 4'd3, 16);
        check("bp_total", bus.total_sum, 24'(bus.sum_out + 24'd5));

        // Total-sum saturation boundary
        mem[0] = vecs[0].row;
        run_pass(2'd1, 4'd0, 5'd1, 1, 24'hFFFFF0, 1'b0);
        check("sat_over", bus.total_sum, 24'hFFFFFF);
        run_pass(2'd1, 4'd0, 5'd1, 1, 24'hFFFFAB, 1'b0);
        check("sat_exact", bus.total_sum, 24'hFFFFFF);
        run_pass(2'd1, 4'd0, 5'd1, 1, 24'hFFFFAA, 1'b0);
        check("sat_below", bus.total_sum, 24'hFFFFFE);

        // num_rows=0 goes straight to the exchange and waits for the peer
        bus.start = 1'b1; bus.num_rows = 5'd0; bus.mode = 2'd0; bus.base_addr = 4'd0;
        @(posedge clk); #1 bus.start = 1'b0;
        zr_bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.pmem_rd || bus.done || !bus.busy || bus.total_valid) zr_bad++;
            @(posedge clk); #1;
        end
        check("zero_rows_wait", zr_bad, 0);
        bus.sum_in = 24'd50; bus.sum_in_valid = 1'b1;
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        bus.sum_in_valid = 1'b0;
        check("zero_rows_done", seen, 1'b1);
        check("zero_rows_total", bus.total_sum, 24'd50);
        check("zero_rows_sum_out", bus.sum_out, 24'd0);
        check("zero_rows_idle", bus.busy, 1'b0);

        // Asynchronous reset in the middle of a stalled pass
        bus.start = 1'b1; bus.num_rows = 5'd16; bus.mode = 2'd0; bus.base_addr = 4'd0; bus.out_ready = 1'b0;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_pre_busy", bus.busy, 1'b1);
        check("mid_pre_sum_nonzero", bus.sum_out != 24'd0, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_pmem_rd", bus.pmem_rd, 1'b0);
        check("mid_rst_sum_out", bus.sum_out, 24'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        mem[1] = vecs[1].row;
        run_pass(vecs[1].mode, 4'd1, 5'd1, 1, 24'd0, 1'b0);
        d0 = (got_data.size() > 0) ? got_data[0] : 'x;
        check("post_rst_timeout", timeout, 1'b0);
        check("post_rst_rows", got_data.size(), 1);
        check("post_rst_data", d0, vecs[1].exp_data);
        check("post_rst_sum_out", bus.sum_out, vecs[1].exp_sum);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
